// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Splits one 16-bit word access into two byte transactions on an 8-bit
// req/ack memory port. The low byte goes to Addr and the high byte to Addr+1,
// with 16-bit wrap. It returns the assembled read word, a one-cycle Done
// pulse and a timeout error flag.
// Optional feature: define MEM_SEQ_AUTOINC_EN to make ArfInc pulse in an
// error-free Done cycle. Without the macro, ArfInc is tied low.
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Write,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [15:0] RData,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemWData,
    output logic        MemReq,
    output logic        MemWr,
    input  logic [7:0]  MemRData,
    input  logic        MemAck,
    output logic        ArfInc
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, FIN} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] tcnt, tcnt_d;
    logic [7:0]       wdata_hi;
    logic [7:0]       lo_byte;

    logic             accept;
    logic             ack_ok;
    logic             waiting;
    logic             timeout_hit;

    logic             busy_d, done_d, err_d, mem_req_d, mem_wr_d;
    logic [15:0]      rdata_d, mem_addr_d;
    logic [7:0]       mem_wdata_d;

    assign accept      = (state == IDLE) && Start;
    assign ack_ok      = MemReq && MemAck;
    assign waiting     = TO_EN && MemReq && !MemAck;
    // The ack test comes first in the next-state logic, so an ack on the
    // same edge as the last wait cycle still completes the byte.
    assign timeout_hit = waiting && ((tcnt + CNT_ONE) == TO_CNT);

    // State register and all registered outputs (async active-low reset)
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            tcnt     <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            RData    <= 16'h0000;
            MemAddr  <= 16'h0000;
            MemWData <= 8'h00;
            MemReq   <= 1'b0;
            MemWr    <= 1'b0;
        end else begin
            state    <= state_d;
            tcnt     <= tcnt_d;
            Busy     <= busy_d;
            Done     <= done_d;
            Err      <= err_d;
            RData    <= rdata_d;
            MemAddr  <= mem_addr_d;
            MemWData <= mem_wdata_d;
            MemReq   <= mem_req_d;
            MemWr    <= mem_wr_d;
        end
    end

    // Captured data bytes: the write high byte and the read low byte
    always_ff @(posedge Clock) begin
        if (accept) begin
            wdata_hi <= WData[15:8];
        end
        if ((state == REQ_LO) && ack_ok) begin
            lo_byte <= MemRData;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (Start) state_d = REQ_LO;
            REQ_LO: begin
                if (ack_ok)           state_d = REQ_HI;
                else if (timeout_hit) state_d = FIN;
            end
            REQ_HI: begin
                if (ack_ok || timeout_hit) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the wait counter
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
        // The first cycle of REQ_LO only presents the address; the request
        // rises one edge later and stays up across both bytes.
        mem_req_d   = (state != IDLE) && ((state_d == REQ_LO) || (state_d == REQ_HI));
        err_d       = Err;
        rdata_d     = RData;
        mem_addr_d  = MemAddr;
        mem_wdata_d = MemWData;
        mem_wr_d    = MemWr;
        tcnt_d      = tcnt;
        case (state)
            IDLE: begin
                if (Start) begin
                    err_d       = 1'b0;
                    rdata_d     = 16'h0000;
                    mem_addr_d  = Addr;
                    mem_wdata_d = WData[7:0];
                    mem_wr_d    = Write;
                    tcnt_d      = '0;
                end
            end
            REQ_LO: begin
                if (ack_ok) begin
                    mem_addr_d  = MemAddr + 16'd1;
                    mem_wdata_d = wdata_hi;
                    tcnt_d      = '0;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else if (waiting) begin
                    tcnt_d = tcnt + CNT_ONE;
                end
            end
            REQ_HI: begin
                if (ack_ok) begin
                    if (!MemWr) rdata_d = {MemRData, lo_byte};
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else if (waiting) begin
                    tcnt_d = tcnt + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_SEQ_AUTOINC_EN
    // Autoincrement request: one pulse alongside an error-free Done
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) ArfInc <= 1'b0;
        else          ArfInc <= (state_d == FIN) && !err_d;
    end
`else
    assign ArfInc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer
// Directed bench for mem_access_sequencer. It models a byte memory with
// programmable ack delay and a forced no-ack mode, and it logs the write
// transactions that memory sees.
module tb_mem_access_sequencer;

`ifdef MEM_SEQ_AUTOINC_EN
    localparam logic ARF_EXP = 1'b1;
`else
    localparam logic ARF_EXP = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        Write;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] RData;
    logic [15:0] MemAddr;
    logic [7:0]  MemWData;
    logic        MemReq;
    logic        MemWr;
    logic [7:0]  MemRData;
    logic        MemAck;
    logic        ArfInc;

    int total = 0;
    int bad   = 0;

    // Memory model state
    logic        ack_block = 1'b0;
    int          ack_delay = 0;
    int          age       = 0;
    int          wn        = 0;
    logic [15:0] wlog_addr [8];
    logic [7:0]  wlog_data [8];
    int          done_cnt  = 0;
    int          arf_stray = 0;

    mem_access_sequencer #(.TIMEOUT(16)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Write    (Write),
        .Addr     (Addr),
        .WData    (WData),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err),
        .RData    (RData),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemReq   (MemReq),
        .MemWr    (MemWr),
        .MemRData (MemRData),
        .MemAck   (MemAck),
        .ArfInc   (ArfInc)
    );

    always #5 Clock = ~Clock;

    // Memory contents at the addresses the bench reads
    always_comb begin
        MemRData = 8'hEE;
        case (MemAddr)
            16'h1000: MemRData = 8'h34;
            16'h1001: MemRData = 8'h12;
            16'hFFFF: MemRData = 8'hA5;
            16'h0000: MemRData = 8'h5A;
            default:  MemRData = 8'hEE;
        endcase
    end

    assign MemAck = MemReq && !ack_block && (age >= ack_delay);

    // Ack-delay age, write log, Done count and stray ArfInc count
    always @(posedge Clock) begin
        if (!MemReq || MemAck) age <= 0;
        else                   age <= age + 1;
        if (MemReq && MemAck && MemWr && (wn < 8)) begin
            wlog_addr[wn] <= MemAddr;
            wlog_data[wn] <= MemWData;
            wn <= wn + 1;
        end
        if (Done) done_cnt <= done_cnt + 1;
        if (ArfInc && !Done) arf_stray <= arf_stray + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Present a command for one edge, then scramble the inputs so that any
    // re-sampling after acceptance would be visible.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
        Start = 1'b1; Write = wr; Addr = a; WData = d;
        tick();
        Start = 1'b0; Write = ~wr; Addr = 16'h5555; WData = 16'h0000;
    endtask

    // Count the edges after acceptance until Done, bounded. Also count the
    // request cycles whose MemWr disagrees with the command.
    task automatic wait_done(output int cyc, input logic exp_wr, output int wr_bad);
        cyc = 0;
        wr_bad = 0;
        while (cyc < 60) begin
            tick();
            cyc++;
            if (MemReq && (MemWr !== exp_wr)) wr_bad++;
            if (Done) break;
        end
    endtask

    initial begin
        int cyc;
        int wrb;
        int d0;

        Reset_n = 1'b0; Start = 1'b0; Write = 1'b0; Addr = 16'h0; WData = 16'h0;
        #2;
        chk("reset_ctrl", {26'd0, Busy, Done, Err, MemReq, MemWr, ArfInc}, 32'd0);
        chk("reset_rdata_addr", {RData, MemAddr}, 32'd0);
        chk("reset_wdata", {24'd0, MemWData}, 32'd0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // 1: zero-wait read at 0x1000, checked edge by edge
        issue(1'b0, 16'h1000, 16'h0000);
        chk("t1_busy_e0", {31'd0, Busy}, 32'd1);
        chk("t1_req_e0", {31'd0, MemReq}, 32'd0);
        tick();
        chk("t1_req_e1", {31'd0, MemReq}, 32'd1);
        chk("t1_addr_lo", {16'd0, MemAddr}, 32'h1000);
        chk("t1_wr_lo", {31'd0, MemWr}, 32'd0);
        tick();
        chk("t1_addr_hi", {16'd0, MemAddr}, 32'h1001);
        chk("t1_req_e2", {31'd0, MemReq}, 32'd1);
        tick();
        chk("t1_done_e3", {31'd0, Done}, 32'd1);
        chk("t1_rdata", {16'd0, RData}, 32'h1234);
        chk("t1_err", {31'd0, Err}, 32'd0);
        chk("t1_arfinc", {31'd0, ArfInc}, {31'd0, ARF_EXP});
        chk("t1_req_fin", {31'd0, MemReq}, 32'd0);
        chk("t1_busy_fin", {31'd0, Busy}, 32'd1);
        tick();
        chk("t1_done_e4", {31'd0, Done}, 32'd0);
        chk("t1_busy_e4", {31'd0, Busy}, 32'd0);
        chk("t1_arf_e4", {31'd0, ArfInc}, 32'd0);

        // 2: write 0xBEEF at 0x2000 with two wait cycles per byte
        ack_delay = 2;
        issue(1'b1, 16'h2000, 16'hBEEF);
        wait_done(cyc, 1'b1, wrb);
        chk("t2_latency", cyc, 32'd7);
        chk("t2_done", {31'd0, Done}, 32'd1);
        chk("t2_memwr", wrb, 32'd0);
        chk("t2_err", {31'd0, Err}, 32'd0);
        chk("t2_rdata", {16'd0, RData}, 32'h0000);
        chk("t2_arfinc", {31'd0, ArfInc}, {31'd0, ARF_EXP});
        tick();
        ack_delay = 0;
        chk("t2_write_count", wn, 32'd2);
        chk("t2_w0", {8'd0, wlog_addr[0], wlog_data[0]}, 32'h002000EF);
        chk("t2_w1", {8'd0, wlog_addr[1], wlog_data[1]}, 32'h002001BE);

        // 3: read at 0xFFFF wraps to 0x0000 for the high byte
        issue(1'b0, 16'hFFFF, 16'h0000);
        tick();
        chk("t3_addr_lo", {16'd0, MemAddr}, 32'hFFFF);
        tick();
        chk("t3_addr_wrap", {16'd0, MemAddr}, 32'h0000);
        tick();
        chk("t3_done", {31'd0, Done}, 32'd1);
        chk("t3_rdata", {16'd0, RData}, 32'h5AA5);
        chk("t3_arfinc", {31'd0, ArfInc}, {31'd0, ARF_EXP});
        tick();

        // 4: no ack at all -> timeout after 16 wait cycles
        ack_block = 1'b1;
        issue(1'b0, 16'h3000, 16'h0000);
        wait_done(cyc, 1'b0, wrb);
        chk("t4_latency", cyc, 32'd17);
        chk("t4_done", {31'd0, Done}, 32'd1);
        chk("t4_err", {31'd0, Err}, 32'd1);
        chk("t4_rdata", {16'd0, RData}, 32'h0000);
        chk("t4_req_dropped", {31'd0, MemReq}, 32'd0);
        chk("t4_arfinc", {31'd0, ArfInc}, 32'd0);
        tick();
        chk("t4_err_held", {31'd0, Err}, 32'd1);
        ack_block = 1'b0;
        issue(1'b0, 16'h1000, 16'h0000);
        chk("t4_err_cleared", {31'd0, Err}, 32'd0);
        wait_done(cyc, 1'b0, wrb);
        chk("t4_good_latency", cyc, 32'd3);
        chk("t4_good_rdata", {16'd0, RData}, 32'h1234);
        chk("t4_good_err", {31'd0, Err}, 32'd0);
        tick();

        // 5a: Start held across REQ_HI and FIN is ignored
        d0 = done_cnt;
        issue(1'b0, 16'h1000, 16'h0000);
        tick();
        tick();
        Start = 1'b1; Write = 1'b1; Addr = 16'h2000;
        tick();
        chk("t5_done_fin", {31'd0, Done}, 32'd1);
        tick();
        chk("t5_busy_after", {31'd0, Busy}, 32'd0);
        chk("t5_req_after", {31'd0, MemReq}, 32'd0);
        Start = 1'b0; Write = 1'b0;
        tick(); tick();
        chk("t5_busy_idle", {31'd0, Busy}, 32'd0);
        chk("t5_one_done", done_cnt - d0, 32'd1);
        chk("t5_rdata", {16'd0, RData}, 32'h1234);

        // 5b: reset in REQ_LO clears everything at once, with no Done
        issue(1'b0, 16'h1000, 16'h0000);
        tick();
        chk("t5_req_before_rst", {31'd0, MemReq}, 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("t5_rst_ctrl", {26'd0, Busy, Done, Err, MemReq, MemWr, ArfInc}, 32'd0);
        chk("t5_rst_rdata_addr", {RData, MemAddr}, 32'd0);
        d0 = done_cnt;
        tick(); tick();
        Reset_n = 1'b1;
        tick();
        chk("t5_no_done", done_cnt - d0, 32'd0);
        chk("t5_idle_busy", {31'd0, Busy}, 32'd0);
        issue(1'b0, 16'hFFFF, 16'h0000);
        wait_done(cyc, 1'b0, wrb);
        chk("t5_post_rst_latency", cyc, 32'd3);
        chk("t5_post_rst_rdata", {16'd0, RData}, 32'h5AA5);
        chk("t5_post_rst_arf", {31'd0, ArfInc}, {31'd0, ARF_EXP});
        tick(); tick();

        // 6: ArfInc never rises outside a Done cycle
        chk("t6_arf_stray", arf_stray, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound: report and stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=stall expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
